seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial pattern detector. It is the next-generation replacement for the fixed 1011 detector. The pattern, its length (1..MAX_LEN) and overlap mode are runtime-configurable, and input bits are qualified by a valid strobe. A registered one-cycle match pulse and a saturating match counter are provided. The block sits on a serial bit stream and feeds status or interrupt logic.

## Interface
- MAX_LEN, 8: maximum pattern length in bits; must be ≥2.
- LEN_W, $clog2(MAX_LEN+1): width of the length field.
- CNT_W, 8: match counter width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled only when high.
- cfg_load  in  1  capture pattern_in, len_in and overlap_in into the shadow config.
- pattern_in  in  MAX_LEN  pattern; pattern_in[L-1] is the first bit received, pattern_in[0] the last.
- len_in  in  LEN_W  pattern length L.
- overlap_in  in  1  1 = overlapping detection, 0 = non-overlapping.
- clear  in  1  synchronous clear of history, fill count and match counter.
- y  out  1  match pulse, registered.
- match_count  out  CNT_W  number of matches, saturating.
- cfg_err  out  1  shadow length is invalid (0 or >MAX_LEN); detection is disabled.

## Operation
- **Shadow config.**
  - Registers: pat_q, len_q, ovl_q.
  - Reset values: pat_q = 0, len_q = 0, ovl_q = 1. cfg_err is therefore 1 out of reset, and no match occurs until a valid load.
- **History register.**
  - hist (MAX_LEN bits) shifts on every accepted bit: hist <= {hist[MAX_LEN-2:0], x}.
  - hist[0] is always the newest bit.
- **Fill counter.**
  - fill counts accepted bits since the last restart, saturating at MAX_LEN.
  - Restart events: reset, clear, cfg_load, and a match in non-overlap mode.
- **Match condition**, evaluated on the post-shift values:
  - x_valid is high,
  - cfg_err is low,
  - fill_next ≥ len_q, and
  - hist_next[len_q-1:0] == pat_q[len_q-1:0]. Bits above len_q are ignored.
- **Control FSM** (2 states):
  - FILLING: fill < len_q.
  - ARMED: fill ≥ len_q.
  - Transitions:
    - FILLING→ARMED when fill reaches len_q.
    - ARMED→FILLING on clear, on cfg_load, or on a match with ovl_q = 0. fill returns to 0 in each case.
  - A match with ovl_q = 1 keeps ARMED; the history is retained, so overlapping matches are found.
- **Match counter.**
  - match_count increments on each match.
  - It saturates at 2^CNT_W−1 and never wraps.
- **Priority**, highest first: rst_n, clear, cfg_load, x_valid.
  - clear and cfg_load in the same cycle: config loads and counters clear.
  - A bit presented with clear or cfg_load is discarded: no shift and no match.
- **x_valid low:** hist, fill and state hold; y = 0.

## Timing
- Reset values: y = 0, match_count = 0, hist = 0, fill = 0, state = FILLING, cfg_err = 1.
- Latency: y rises in the cycle after the clock edge that samples the final pattern bit. It is high for exactly one cycle per match.
- match_count updates on the same edge that raises y.
- cfg_err is registered from len_q. It is valid one cycle after cfg_load.
- Back-to-back matches are possible, with y high on consecutive cycles:
  - overlap mode, L = 1;
  - periodic patterns with period 1 (for example 11 on an all-1s stream).
- If rst_n is asserted mid-pattern, all state clears immediately. A partial pattern never completes across reset.

## Structure
- Package seq_detect_pkg holds:
  - state enum {S_FILLING, S_ARMED};
  - default MAX_LEN and CNT_W constants;
  - function len_valid(len, max).
- Sub-module seq_match_cmp: combinational masked compare of hist_next against pat_q over len_q bits. It outputs hit.
- The top level holds the config shadow, the FSM, the history shift, the fill counter and the match counter.

## Test plan
- **Overlap mode.** Load pattern 4'b1011, L = 4, overlap = 1. Stream 1,0,1,1,0,1,1 with x_valid always high. Required: y pulses after bits 4 and 7; match_count = 2.
- **Non-overlap mode.** Same load and stream with overlap = 0. Required: one y pulse, after bit 4; match_count = 1.
- **Gapped valid.** Present the stream 1011 with x_valid low between each bit, and random x during the gaps. Required: one match, y one cycle after the 4th valid bit. Gap data is ignored.
- **Full length.** L = 8, pattern 8'hA5. Required: matches 10100101. A 7-bit prefix alone gives no match. L = 0 load gives cfg_err = 1 and no y on any stream.
- **Saturation.** CNT_W = 2, L = 1, pattern 1, overlap = 1, six consecutive 1s. Required: six y pulses; match_count stops at 3.
- **Reset, clear and load priority.**
  - Assert rst_n low after bits 1,0,1 of 1011, then release and send 1. Required: no match. The config returns to reset values, so cfg_err = 1 until reloaded.
  - Same check using clear instead of rst_n. Required: no match.
  - Assert cfg_load together with x_valid. Required: that bit is discarded.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_detect_pkg;

  localparam int DEFAULT_MAX_LEN = 8;
  localparam int DEFAULT_CNT_W   = 8;

  typedef enum logic {
    S_FILLING = 1'b0,
    S_ARMED   = 1'b1
  } state_t;

  // A pattern length is usable only when it selects at least one history bit.
  function automatic logic len_valid(input int unsigned len, input int unsigned max_len);
    return (len != 0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Masked comparison of the post-shift history against the low len bits of the pattern.
module seq_match_cmp #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] hist,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  assign hit = (((hist ^ pat) & mask) == '0);

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector with a registered match pulse
// and a saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               overlap_in,
  input  logic               clear,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic               cfg_err_q;

  logic [MAX_LEN-1:0] hist_q;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   fill_next;
  state_t             state_q;
  state_t             state_next;

  logic accept;
  logic ready;
  logic hit;
  logic match;

  // clear and cfg_load both discard the bit presented alongside them.
  assign accept = x_valid && !clear && !cfg_load;

  // Oldest bit falls off the top; the truncating cast keeps the shift full width.
  assign hist_next = MAX_LEN'({hist_q, x});
  assign fill_inc  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;

  seq_match_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .hist (hist_next),
    .pat  (pat_q),
    .len  (len_q),
    .hit  (hit)
  );

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_next = state_q;
    fill_next  = fill_q;
    ready      = 1'b0;
    match      = 1'b0;

    case (state_q)
      S_FILLING: ready = !cfg_err_q && (fill_inc >= len_q);
      S_ARMED:   ready = 1'b1;
      default:   ready = 1'b0;
    endcase

    if (clear || cfg_load) begin
      state_next = S_FILLING;
      fill_next  = '0;
    end else if (accept) begin
      match     = ready && !cfg_err_q && hit;
      fill_next = fill_inc;
      if (match && !ovl_q) begin
        state_next = S_FILLING;
        fill_next  = '0;
      end else if (ready) begin
        state_next = S_ARMED;
      end
    end
  end

  // cfg_err is captured with the shadow length so it always describes len_q.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b1;
      cfg_err_q <= 1'b1;
    end else if (cfg_load) begin
      pat_q     <= pattern_in;
      len_q     <= len_in;
      ovl_q     <= overlap_in;
      cfg_err_q <= !len_valid(32'(len_in), MAX_LEN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILLING;
      fill_q      <= '0;
      hist_q      <= '0;
      y           <= 1'b0;
      match_count <= '0;
    end else begin
      state_q <= state_next;
      fill_q  <= fill_next;
      y       <= match;

      if (clear) begin
        hist_q <= '0;
      end else if (accept) begin
        hist_q <= hist_next;
      end

      if (clear) begin
        match_count <= '0;
      end else if (match && (match_count != '1)) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomised and directed bench for seq_detect_param, checked every cycle
// against a bit-queue model of the detector.
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_W_S = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int CNT_MAX_S = (1 << CNT_W_S) - 1;

  logic               clk;
  logic               rst_n;
  logic               x;
  logic               x_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern_in;
  logic [LEN_W-1:0]   len_in;
  logic               overlap_in;
  logic               clear;
  logic               y;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;
  logic               y_s;
  logic [CNT_W_S-1:0] match_count_s;
  logic               cfg_err_s;

  seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (x),
    .x_valid     (x_valid),
    .cfg_load    (cfg_load),
    .pattern_in  (pattern_in),
    .len_in      (len_in),
    .overlap_in  (overlap_in),
    .clear       (clear),
    .y           (y),
    .match_count (match_count),
    .cfg_err     (cfg_err)
  );

  // Narrow-counter copy on the same inputs, to exercise saturation.
  seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W_S)) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (x),
    .x_valid     (x_valid),
    .cfg_load    (cfg_load),
    .pattern_in  (pattern_in),
    .len_in      (len_in),
    .overlap_in  (overlap_in),
    .clear       (clear),
    .y           (y_s),
    .match_count (match_count_s),
    .cfg_err     (cfg_err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int pulses_s = 0;

  // Model: the accepted bits since the last restart, newest at the back.
  bit               m_bits[$];
  logic [MAX_LEN-1:0] m_pat;
  int               m_len;
  bit               m_ovl;
  int               m_cnt;
  int               m_cnt_s;
  bit               exp_y;
  bit               exp_cfg_err;
  bit               skip_cfg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit len_ok(input int l);
    return (l >= 1) && (l <= MAX_LEN);
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_pat       = '0;
    m_len       = 0;
    m_ovl       = 1'b1;
    m_cnt       = 0;
    m_cnt_s     = 0;
    exp_y       = 1'b0;
    exp_cfg_err = 1'b1;
    skip_cfg    = 1'b0;
  endtask

  task automatic model_step(input bit xb, input bit xv, input bit ld, input bit clr,
                            input logic [MAX_LEN-1:0] pin, input int lin, input bit oin);
    bit hitm;
    int n;
    exp_y    = 1'b0;
    skip_cfg = ld;
    if (ld) begin
      m_pat = pin;
      m_len = lin;
      m_ovl = oin;
    end
    if (clr || ld) begin
      m_bits.delete();
      if (clr) begin
        m_cnt   = 0;
        m_cnt_s = 0;
      end
    end else if (xv) begin
      m_bits.push_back(xb);
      if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
      n = m_bits.size();
      if (len_ok(m_len) && (n >= m_len)) begin
        hitm = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (m_bits[n-1-i] != m_pat[i]) hitm = 1'b0;
        if (hitm) begin
          exp_y   = 1'b1;
          m_cnt   = (m_cnt   < CNT_MAX)   ? m_cnt + 1   : m_cnt;
          m_cnt_s = (m_cnt_s < CNT_MAX_S) ? m_cnt_s + 1 : m_cnt_s;
          if (!m_ovl) m_bits.delete();
        end
      end
    end
    exp_cfg_err = !len_ok(m_len);
  endtask

  // Single compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    check("y", 32'(y), 32'(exp_y));
    check("match_count", 32'(match_count), 32'(m_cnt));
    check("y_sat", 32'(y_s), 32'(exp_y));
    check("match_count_sat", 32'(match_count_s), 32'(m_cnt_s));
    if (!skip_cfg) begin
      check("cfg_err", 32'(cfg_err), 32'(exp_cfg_err));
      check("cfg_err_sat", 32'(cfg_err_s), 32'(exp_cfg_err));
    end
    if (y === 1'b1)   pulses++;
    if (y_s === 1'b1) pulses_s++;
  end

  // One clock of stimulus; inputs return to idle once the edge has taken them.
  task automatic drive(input bit xb, input bit xv, input bit ld, input bit clr);
    @(negedge clk);
    x        = xb;
    x_valid  = xv;
    cfg_load = ld;
    clear    = clr;
    @(posedge clk);
    #1;
    model_step(xb, xv, ld, clr, pattern_in, int'(len_in), overlap_in);
    x_valid  = 1'b0;
    cfg_load = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic settle();
    drive(1'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_y", 32'(y), 32'd0);
    check("reset_count", 32'(match_count), 32'd0);
    check("reset_cfg_err", 32'(cfg_err), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input int len, input bit ovl, input bit xv);
    pattern_in = pat;
    len_in     = LEN_W'(len);
    overlap_in = ovl;
    drive(1'($urandom), xv, 1'b1, 1'b0);
  endtask

  task automatic stream(input logic [MAX_LEN-1:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive(bits[i], 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    x          = 1'b0;
    x_valid    = 1'b0;
    cfg_load   = 1'b0;
    pattern_in = '0;
    len_in     = '0;
    overlap_in = 1'b0;
    clear      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    // Overlap: 1011011 holds 1011 twice.
    do_reset();
    load(8'h0B, 4, 1'b1, 1'b0);
    pulses = 0;
    stream(8'b0101_1011, 7);
    settle();
    check("ovl_pulses", 32'(pulses), 32'd2);
    check("ovl_count", 32'(match_count), 32'd2);

    // Non-overlap: second occurrence shares a bit, so it is not seen.
    do_reset();
    load(8'h0B, 4, 1'b0, 1'b0);
    pulses = 0;
    stream(8'b0101_1011, 7);
    settle();
    check("novl_pulses", 32'(pulses), 32'd1);
    check("novl_count", 32'(match_count), 32'd1);

    // Gapped valid with random data in the gaps.
    do_reset();
    load(8'h0B, 4, 1'b1, 1'b0);
    pulses = 0;
    for (int i = 3; i >= 0; i--) begin
      drive(4'b1011 >> i, 1'b1, 1'b0, 1'b0);
      repeat ($urandom_range(1, 3)) drive(1'($urandom), 1'b0, 1'b0, 1'b0);
    end
    check("gap_pulses", 32'(pulses), 32'd1);
    check("gap_count", 32'(match_count), 32'd1);

    // Full length pattern: 7-bit prefix alone must not match.
    do_reset();
    load(8'hA5, 8, 1'b1, 1'b0);
    pulses = 0;
    stream(8'b0101_0010, 7);
    settle();
    check("full_prefix_pulses", 32'(pulses), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    check("full_pulses", 32'(pulses), 32'd1);

    // Zero length disables detection.
    load(8'hA5, 0, 1'b1, 1'b0);
    settle();
    check("len0_cfg_err", 32'(cfg_err), 32'd1);
    pulses = 0;
    repeat (30) drive(1'($urandom), 1'b1, 1'b0, 1'b0);
    settle();
    check("len0_pulses", 32'(pulses), 32'd0);

    // Saturation on the narrow counter.
    do_reset();
    load(8'h01, 1, 1'b1, 1'b0);
    pulses_s = 0;
    repeat (6) drive(1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    check("sat_pulses", 32'(pulses_s), 32'd6);
    check("sat_count", 32'(match_count_s), 32'd3);
    check("sat_wide_count", 32'(match_count), 32'd6);

    // Reset mid-pattern: config and partial history are lost.
    do_reset();
    load(8'h0B, 4, 1'b1, 1'b0);
    stream(8'b0000_0101, 3);
    do_reset();
    check("rst_mid_cfg_err", 32'(cfg_err), 32'd1);
    pulses = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    load(8'h0B, 4, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    check("rst_mid_pulses", 32'(pulses), 32'd0);

    // Clear mid-pattern, with a valid bit riding on the clear.
    do_reset();
    load(8'h0B, 4, 1'b1, 1'b0);
    stream(8'b0000_0101, 3);
    pulses = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    check("clr_mid_pulses", 32'(pulses), 32'd0);
    check("clr_mid_count", 32'(match_count), 32'd0);

    // A bit presented with cfg_load is discarded.
    do_reset();
    pulses = 0;
    load(8'h01, 1, 1'b1, 1'b1);
    settle();
    check("load_bit_pulses", 32'(pulses), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    check("load_after_pulses", 32'(pulses), 32'd1);

    // Randomised traffic with occasional clear and invalid lengths.
    do_reset();
    repeat (40) begin
      load(MAX_LEN'($urandom),
           ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 10)),
           1'($urandom), 1'($urandom));
      repeat ($urandom_range(20, 80))
        drive(1'($urandom), ($urandom_range(0, 3) != 0), 1'b0, ($urandom_range(0, 49) == 0));
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
